// File: rtl/miss_handler_pkg.sv
// Shared definitions for the cache miss handler: FSM encoding, victim field
// layout and the default main-memory latency.
package miss_handler_pkg;

   typedef enum logic [1:0] {
      S_IDLE       = 2'd0,
      S_WB_WAIT    = 2'd1,
      S_FETCH_WAIT = 2'd2,
      S_FILL       = 2'd3
   } state_t;

   localparam int MEM_LAT_DEFAULT = 3;

   // Victim word layout: {valid, dirty, addr[3:0], data[7:0]}
   localparam int WB_V       = 13;
   localparam int WB_D       = 12;
   localparam int WB_A_HI    = 11;
   localparam int WB_A_LO    = 8;
   localparam int WB_DATA_HI = 7;
   localparam int WB_DATA_LO = 0;

   function automatic logic [7:0] sat_inc(input logic [7:0] value);
      return (value == 8'hFF) ? value : value + 8'd1;
   endfunction

endpackage

// File: rtl/mem_16x8.sv
// 16x8 main memory: one write port and one registered read port; reset
// reloads the identity pattern mem[i] = i.
module mem_16x8 (
   input  logic       clock,
   input  logic       reset,
   input  logic       wr_en,
   input  logic [3:0] wr_addr,
   input  logic [7:0] wr_data,
   input  logic       rd_en,
   input  logic [3:0] rd_addr,
   output logic [7:0] rd_data
);

   logic [7:0] mem [16];

   // NOTE: a reset on a storage array maps it to flops rather than a RAM
   // macro; that cost is accepted because reset must restore known contents.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 16; i++) begin
            mem[i] <= 8'(i);
         end
         rd_data <= '0;
      end else begin
         if (wr_en) begin
            mem[wr_addr] <= wr_data;
         end
         if (rd_en) begin
            rd_data <= mem[rd_addr];
         end
      end
   end

endmodule

// File: rtl/miss_handler.sv
// Cache miss handler: optional victim write-back, then a fetch from main
// memory, each taking MEM_LAT cycles, ending with a one-cycle fill pulse.
module miss_handler
   import miss_handler_pkg::*;
#(
   parameter int MEM_LAT = MEM_LAT_DEFAULT
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        miss_req,
   input  logic [3:0]  endereco,
   input  logic        WB_needed,
   input  logic [13:0] WB,
   output logic        busy,
   output logic        fill_valid,
   output logic [3:0]  fill_addr,
   output logic [7:0]  fill_data,
   output logic [7:0]  wb_count
);

   localparam logic [3:0] LAT_LOAD = 4'(MEM_LAT - 1);

   state_t     state;
   logic [3:0] cnt;
   logic [3:0] req_addr;
   logic [3:0] victim_addr;
   logic [7:0] victim_data;
   logic       do_wb;
   logic       wb_done;
   logic       fetch_done;

   // Only a valid, dirty victim that the cache asks to evict costs a write-back.
   assign do_wb      = WB_needed & WB[WB_V] & WB[WB_D];
   assign wb_done    = (state == S_WB_WAIT)    && (cnt == 4'd0);
   assign fetch_done = (state == S_FETCH_WAIT) && (cnt == 4'd0);

   // NOTE: all state below is updated with non-blocking assignments so every
   // register samples pre-edge values, independent of statement order.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state       <= S_IDLE;
         cnt         <= '0;
         req_addr    <= '0;
         victim_addr <= '0;
         victim_data <= '0;
         busy        <= 1'b0;
         fill_valid  <= 1'b0;
         fill_addr   <= '0;
         wb_count    <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (miss_req) begin
                  req_addr    <= endereco;
                  victim_addr <= WB[WB_A_HI:WB_A_LO];
                  victim_data <= WB[WB_DATA_HI:WB_DATA_LO];
                  cnt         <= LAT_LOAD;
                  busy        <= 1'b1;
                  state       <= do_wb ? S_WB_WAIT : S_FETCH_WAIT;
               end
            end
            S_WB_WAIT: begin
               if (wb_done) begin
                  wb_count <= sat_inc(wb_count);
                  cnt      <= LAT_LOAD;
                  state    <= S_FETCH_WAIT;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            S_FETCH_WAIT: begin
               if (fetch_done) begin
                  fill_addr  <= req_addr;
                  fill_valid <= 1'b1;
                  state      <= S_FILL;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            S_FILL: begin
               fill_valid <= 1'b0;
               busy       <= 1'b0;
               state      <= S_IDLE;
            end
            default: begin
               busy       <= 1'b0;
               fill_valid <= 1'b0;
               state      <= S_IDLE;
            end
         endcase
      end
   end

   // The write lands on the WB_WAIT exit edge, a full wait period before the
   // fetch reads, so a same-address fill returns the evicted data.
   mem_16x8 u_mem (
      .clock   (clock),
      .reset   (reset),
      .wr_en   (wb_done),
      .wr_addr (victim_addr),
      .wr_data (victim_data),
      .rd_en   (fetch_done),
      .rd_addr (req_addr),
      .rd_data (fill_data)
   );

endmodule

// File: tb/tb_miss_handler.sv
// Self-checking bench for miss_handler: directed scenarios plus randomized
// misses compared against an array-based reference model.
module tb_miss_handler;

   localparam int LAT = 3;

   logic        clock;
   logic        reset;
   logic        miss_req;
   logic [3:0]  endereco;
   logic        WB_needed;
   logic [13:0] WB;
   logic        busy;
   logic        fill_valid;
   logic [3:0]  fill_addr;
   logic [7:0]  fill_data;
   logic [7:0]  wb_count;

   int passed = 0;
   int total  = 0;

   // Reference model state: memory image and write-back count.
   logic [7:0] m_mem [16];
   int         m_wbc;

   typedef struct {
      int         lat;
      logic [3:0] fa;
      logic [7:0] fd;
      logic       busy_start;
      logic       pulse_after;
      logic       busy_after;
      logic       hold_ok;
   } obs_t;

   miss_handler #(.MEM_LAT(LAT)) dut (
      .clock      (clock),
      .reset      (reset),
      .miss_req   (miss_req),
      .endereco   (endereco),
      .WB_needed  (WB_needed),
      .WB         (WB),
      .busy       (busy),
      .fill_valid (fill_valid),
      .fill_addr  (fill_addr),
      .fill_data  (fill_data),
      .wb_count   (wb_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

   task automatic model_reset();
      for (int i = 0; i < 16; i++) m_mem[i] = 8'(i);
      m_wbc = 0;
   endtask

   task automatic model_miss(input logic [3:0] a, input logic wbn, input logic [13:0] wb,
                             output int lat, output logic [7:0] data);
      logic wr;
      wr = wbn && wb[13] && wb[12];
      if (wr) begin
         m_mem[wb[11:8]] = wb[7:0];
         if (m_wbc < 255) m_wbc++;
      end
      data = m_mem[a];
      lat  = wr ? 2 * LAT : LAT;
   endtask

   // Called at the first negedge after the accepting edge.
   task automatic wait_fill(output obs_t o);
      o.busy_start = busy;
      o.lat = 0;
      while (fill_valid !== 1'b1 && o.lat < 64) begin
         @(negedge clock);
         o.lat++;
      end
      if (fill_valid !== 1'b1) o.lat = -1;
      o.fa = fill_addr;
      o.fd = fill_data;
      @(negedge clock);
      o.pulse_after = fill_valid;
      o.busy_after  = busy;
      o.hold_ok     = (fill_addr === o.fa) && (fill_data === o.fd);
   endtask

   // Called at a negedge; returns at a negedge one cycle after the fill.
   task automatic do_miss(input logic [3:0] a, input logic wbn, input logic [13:0] wb,
                          output obs_t o);
      miss_req  = 1'b1;
      endereco  = a;
      WB_needed = wbn;
      WB        = wb;
      @(negedge clock);
      miss_req  = 1'b0;
      endereco  = 4'($urandom);
      WB_needed = 1'b1;
      WB        = 14'($urandom);
      wait_fill(o);
   endtask

   task automatic test_reset();
      reset = 1'b0; miss_req = 1'b0; endereco = '0; WB_needed = 1'b0; WB = '0;
      model_reset();
      @(negedge clock);
      miss_req = 1'b1;
      @(negedge clock);
      total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
      total++; if (fill_valid !== 1'b0) $display("FAIL reset_fill_valid: got %b want 0", fill_valid); else passed++;
      total++; if (fill_addr !== 4'd0) $display("FAIL reset_fill_addr: got %0d want 0", fill_addr); else passed++;
      total++; if (fill_data !== 8'd0) $display("FAIL reset_fill_data: got %0d want 0", fill_data); else passed++;
      total++; if (wb_count !== 8'd0) $display("FAIL reset_wb_count: got %0d want 0", wb_count); else passed++;
      miss_req = 1'b0;
      reset    = 1'b1;
   endtask

   // Starts on the release negedge, so acceptance is the first edge after reset.
   task automatic test_clean_miss();
      obs_t o; int el; logic [7:0] ed;
      model_miss(4'b0110, 1'b0, 14'd0, el, ed);
      do_miss(4'b0110, 1'b0, 14'd0, o);
      total++; if (o.busy_start !== 1'b1) $display("FAIL clean_busy: got %b want 1", o.busy_start); else passed++;
      total++; if (o.lat !== 3) $display("FAIL clean_latency: got %0d want 3", o.lat); else passed++;
      total++; if (o.fa !== 4'd6) $display("FAIL clean_fill_addr: got %0d want 6", o.fa); else passed++;
      total++; if (o.fd !== 8'd6) $display("FAIL clean_fill_data: got %0d want 6", o.fd); else passed++;
      total++; if (wb_count !== 8'd0) $display("FAIL clean_wb_count: got %0d want 0", wb_count); else passed++;
      total++; if (o.pulse_after !== 1'b0) $display("FAIL clean_pulse_width: got %b want 0", o.pulse_after); else passed++;
      total++; if (o.busy_after !== 1'b0) $display("FAIL clean_busy_after: got %b want 0", o.busy_after); else passed++;
      total++; if (o.hold_ok !== 1'b1) $display("FAIL clean_fill_hold: got %b want 1", o.hold_ok); else passed++;
   endtask

   task automatic test_dirty_eviction();
      obs_t o; int el; logic [7:0] ed;
      model_miss(4'b0001, 1'b1, 14'b11_0101_00101010, el, ed);
      do_miss(4'b0001, 1'b1, 14'b11_0101_00101010, o);
      total++; if (o.lat !== 6) $display("FAIL dirty_latency: got %0d want 6", o.lat); else passed++;
      total++; if (o.fa !== 4'd1) $display("FAIL dirty_fill_addr: got %0d want 1", o.fa); else passed++;
      total++; if (o.fd !== 8'd1) $display("FAIL dirty_fill_data: got %0d want 1", o.fd); else passed++;
      total++; if (wb_count !== 8'd1) $display("FAIL dirty_wb_count: got %0d want 1", wb_count); else passed++;
      model_miss(4'd5, 1'b0, 14'd0, el, ed);
      do_miss(4'd5, 1'b0, 14'd0, o);
      total++; if (o.fd !== 8'd42) $display("FAIL dirty_mem5: got %0d want 42", o.fd); else passed++;
      total++; if (o.lat !== 3) $display("FAIL dirty_readback_latency: got %0d want 3", o.lat); else passed++;
   endtask

   task automatic test_same_addr();
      obs_t o; int el; logic [7:0] ed;
      model_miss(4'd5, 1'b1, {2'b11, 4'd5, 8'd99}, el, ed);
      do_miss(4'd5, 1'b1, {2'b11, 4'd5, 8'd99}, o);
      total++; if (o.fd !== 8'd99) $display("FAIL same_addr_data: got %0d want 99", o.fd); else passed++;
      total++; if (o.lat !== 6) $display("FAIL same_addr_latency: got %0d want 6", o.lat); else passed++;
      total++; if (wb_count !== 8'd2) $display("FAIL same_addr_wb_count: got %0d want 2", wb_count); else passed++;
   endtask

   task automatic test_clean_victim();
      obs_t o; int el; logic [7:0] ed;
      model_miss(4'd9, 1'b1, {2'b10, 4'd9, 8'd77}, el, ed);
      do_miss(4'd9, 1'b1, {2'b10, 4'd9, 8'd77}, o);
      total++; if (o.lat !== 3) $display("FAIL clean_victim_latency: got %0d want 3", o.lat); else passed++;
      total++; if (o.fd !== 8'd9) $display("FAIL clean_victim_data: got %0d want 9", o.fd); else passed++;
      total++; if (wb_count !== 8'd2) $display("FAIL clean_victim_wb_count: got %0d want 2", wb_count); else passed++;
      model_miss(4'd9, 1'b1, {2'b01, 4'd9, 8'd77}, el, ed);
      do_miss(4'd9, 1'b1, {2'b01, 4'd9, 8'd77}, o);
      total++; if (o.lat !== 3) $display("FAIL invalid_victim_latency: got %0d want 3", o.lat); else passed++;
      total++; if (o.fd !== 8'd9) $display("FAIL invalid_victim_data: got %0d want 9", o.fd); else passed++;
      total++; if (wb_count !== 8'd2) $display("FAIL invalid_victim_wb_count: got %0d want 2", wb_count); else passed++;
   endtask

   // miss_req stays high through the whole first miss with a dirty second request.
   task automatic test_back_to_back();
      obs_t o; int el1, el2; logic [7:0] ed1, ed2;
      model_miss(4'd3, 1'b0, 14'd0, el1, ed1);
      miss_req = 1'b1; endereco = 4'd3; WB_needed = 1'b0; WB = '0;
      @(negedge clock);
      endereco = 4'd12; WB_needed = 1'b1; WB = {2'b11, 4'd12, 8'hEE};
      wait_fill(o);
      total++; if (o.lat !== el1) $display("FAIL b2b_first_latency: got %0d want %0d", o.lat, el1); else passed++;
      total++; if (o.fd !== ed1) $display("FAIL b2b_first_data: got %0d want %0d", o.fd, ed1); else passed++;
      total++; if (o.fa !== 4'd3) $display("FAIL b2b_first_addr: got %0d want 3", o.fa); else passed++;
      total++; if (o.pulse_after !== 1'b0) $display("FAIL b2b_single_pulse: got %b want 0", o.pulse_after); else passed++;
      total++; if (o.busy_after !== 1'b0) $display("FAIL b2b_fill_cycle_not_accepted: got busy=%b want 0", o.busy_after); else passed++;
      model_miss(4'd12, 1'b1, {2'b11, 4'd12, 8'hEE}, el2, ed2);
      @(negedge clock);
      miss_req = 1'b0;
      wait_fill(o);
      total++; if (o.busy_start !== 1'b1) $display("FAIL b2b_second_accept: got busy=%b want 1", o.busy_start); else passed++;
      total++; if (o.lat !== el2) $display("FAIL b2b_second_latency: got %0d want %0d", o.lat, el2); else passed++;
      total++; if (o.fd !== ed2) $display("FAIL b2b_second_data: got %0d want %0d", o.fd, ed2); else passed++;
      total++; if (wb_count !== 8'(m_wbc)) $display("FAIL b2b_wb_count: got %0d want %0d", wb_count, m_wbc); else passed++;
   endtask

   task automatic test_random();
      obs_t o; int el; logic [7:0] ed; logic [3:0] a; logic wbn; logic [13:0] wb;
      for (int n = 0; n < 330; n++) begin
         a   = 4'($urandom_range(0, 15));
         wbn = ($urandom_range(0, 9) != 0);
         wb  = {(($urandom_range(0, 9) != 0) ? 2'b11 : 2'($urandom)), 4'($urandom), 8'($urandom)};
         for (int g = $urandom_range(0, 2); g > 0; g--) @(negedge clock);
         model_miss(a, wbn, wb, el, ed);
         do_miss(a, wbn, wb, o);
         total++; if (o.lat !== el) $display("FAIL rand_latency[%0d]: got %0d want %0d", n, o.lat, el); else passed++;
         total++; if (o.fa !== a) $display("FAIL rand_fill_addr[%0d]: got %0d want %0d", n, o.fa, a); else passed++;
         total++; if (o.fd !== ed) $display("FAIL rand_fill_data[%0d]: got %0d want %0d", n, o.fd, ed); else passed++;
         total++; if (wb_count !== 8'(m_wbc)) $display("FAIL rand_wb_count[%0d]: got %0d want %0d", n, wb_count, m_wbc); else passed++;
         total++; if (o.pulse_after !== 1'b0 || o.busy_after !== 1'b0)
            $display("FAIL rand_return_idle[%0d]: got fill_valid=%b busy=%b want 0 0", n, o.pulse_after, o.busy_after);
         else passed++;
      end
   endtask

   task automatic test_saturation();
      obs_t o; int el; logic [7:0] ed; int guard;
      guard = 0;
      while ((m_wbc < 255 || guard < 3) && guard < 400) begin
         if (m_wbc >= 255) guard = guard + 1;
         else guard = (guard > 300) ? guard : guard;
         model_miss(4'd7, 1'b1, {2'b11, 4'($urandom), 8'($urandom)}, el, ed);
         do_miss(4'd7, 1'b1, {2'b11, 4'd0, 8'd0} | {2'b00, m_mem[0][3:0] ^ 4'd0, 8'd0}, o);
         if (m_wbc < 255 && guard == 0 && wb_count === 8'd255) guard = 400;
      end
      total++; if (wb_count !== 8'd255) $display("FAIL wb_count_saturate: got %0d want 255", wb_count); else passed++;
   endtask

   task automatic test_reset_mid();
      obs_t o; int el; logic [7:0] ed; int pulses;
      miss_req = 1'b1; endereco = 4'd2; WB_needed = 1'b1; WB = {2'b11, 4'd5, 8'hAA};
      @(negedge clock);
      miss_req = 1'b0;
      @(negedge clock);
      #1 reset = 1'b0;
      #1;
      total++; if (busy !== 1'b0) $display("FAIL mid_reset_busy: got %b want 0", busy); else passed++;
      total++; if (fill_valid !== 1'b0) $display("FAIL mid_reset_fill_valid: got %b want 0", fill_valid); else passed++;
      total++; if (wb_count !== 8'd0) $display("FAIL mid_reset_wb_count: got %0d want 0", wb_count); else passed++;
      total++; if (fill_addr !== 4'd0 || fill_data !== 8'd0)
         $display("FAIL mid_reset_fill_regs: got addr=%0d data=%0d want 0 0", fill_addr, fill_data);
      else passed++;
      model_reset();
      @(negedge clock);
      reset = 1'b1;
      pulses = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clock);
         if (fill_valid === 1'b1 || busy === 1'b1) pulses++;
      end
      total++; if (pulses !== 0) $display("FAIL mid_reset_no_fill: got %0d active cycles want 0", pulses); else passed++;
      model_miss(4'd5, 1'b0, 14'd0, el, ed);
      do_miss(4'd5, 1'b0, 14'd0, o);
      total++; if (o.fd !== 8'd5) $display("FAIL mid_reset_mem5: got %0d want 5", o.fd); else passed++;
      total++; if (o.fd !== ed) $display("FAIL mid_reset_model: got %0d want %0d", o.fd, ed); else passed++;
      total++; if (o.lat !== 3) $display("FAIL mid_reset_latency: got %0d want 3", o.lat); else passed++;
   endtask

   initial begin
      test_reset();
      test_clean_miss();
      test_dirty_eviction();
      test_same_addr();
      test_clean_victim();
      test_back_to_back();
      test_random();
      test_saturation();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/miss_handler.md
MISS_HANDLER -- requirements
Module: miss_handler

Interface
REQ-001 SHALL have parameter MEM_LAT, default 3: main-memory access latency in cycles; legal range 1..15.
REQ-002 SHALL have port clock  input  1  single clock; all state updates on posedge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port miss_req  input  1  cache reports a miss for endereco; sampled only in IDLE.
REQ-005 SHALL have port endereco  input  4  address of the missing word (bits [3:2] index, [1:0] tag).
REQ-006 SHALL have port WB_needed  input  1  victim line must be written back before the fill.
REQ-007 SHALL have port WB  input  14  victim: [13] valid, [12] dirty, [11:8] address, [7:0] data.
REQ-008 SHALL have port busy  output  1  handler is servicing a miss.
REQ-009 SHALL have port fill_valid  output  1  one-cycle pulse; fill_addr/fill_data are valid.
REQ-010 SHALL have port fill_addr  output  4  address being returned to the cache.
REQ-011 SHALL have port fill_data  output  8  word read from main memory.
REQ-012 SHALL have port wb_count  output  8  number of completed write-backs, saturating at 255.

Function
REQ-013 SHALL hold a 16x8 main memory. Reset contents: mem[i] = i, zero-extended to 8 bits.
REQ-014 SHALL implement the FSM states IDLE, WB_WAIT, FETCH_WAIT and FILL.
REQ-015 In IDLE with miss_req=1, the FSM SHALL latch the following at the accepting edge:
  - endereco;
  - WB;
  - do_wb = WB_needed & WB[13] & WB[12].
REQ-016 On that accepting edge, the next state SHALL be WB_WAIT if do_wb=1, else FETCH_WAIT.
REQ-017 Each wait state SHALL load a 4-bit down-counter with MEM_LAT-1 on entry and decrement it every cycle.
REQ-018 Each wait state SHALL last exactly MEM_LAT cycles; the state exits on the edge where the counter reads 0.
REQ-019 On the WB_WAIT exit edge, the FSM SHALL:
  - write mem[WB[11:8]] <= WB[7:0];
  - increment wb_count, saturating at 255;
  - go to FETCH_WAIT.
REQ-020 On the FETCH_WAIT exit edge, the FSM SHALL:
  - register fill_data <= mem[latched endereco] and fill_addr <= latched endereco;
  - go to FILL.
REQ-021 FILL SHALL last one cycle with fill_valid=1, then return to IDLE.
REQ-022 busy SHALL be 1 in every state except IDLE; fill_valid SHALL be 1 only in FILL.
REQ-023 Latency from the accepting edge to the fill_valid cycle SHALL be MEM_LAT cycles without write-back and 2*MEM_LAT with write-back.
REQ-024 If the victim address equals endereco, the fill SHALL return the just-written data, because the write precedes the fetch.
REQ-025 miss_req, WB_needed and WB SHALL be ignored while busy=1, with no queuing.
REQ-026 miss_req asserted during the FILL cycle SHALL NOT be accepted; acceptance resumes in the next IDLE cycle.
REQ-027 WB_needed=1 with a victim that is invalid or clean SHALL skip WB_WAIT and SHALL NOT count as a write-back.
REQ-028 fill_addr and fill_data SHALL hold their last values outside FILL.

Reset
REQ-029 reset=0 SHALL, asynchronously:
  - force IDLE, counter=0, busy=0, fill_valid=0, fill_addr=0, fill_data=0, wb_count=0;
  - restore the memory contents of REQ-013.
REQ-030 Reset asserted mid-operation SHALL abort the miss with no memory write and no fill pulse.
REQ-031 The first acceptance SHALL be possible on the first rising edge after reset deasserts.

Structure
REQ-032 A shared package SHALL hold:
  - the FSM state encoding;
  - WB field positions (WB_V=13, WB_D=12, WB_A=11:8, WB_DATA=7:0);
  - the MEM_LAT default.
REQ-033 Main memory SHALL be the sub-module mem_16x8, with one write port and one registered read.
REQ-034 FSM, counter and statistics SHALL live in miss_handler.

Verification
REQ-035 Clean miss: MEM_LAT=3, endereco=4'b0110, WB_needed=0 -> fill_valid=1 three cycles after acceptance, fill_addr=6, fill_data=6, wb_count=0.
REQ-036 Dirty eviction: endereco=4'b0001, WB=14'b11_0101_00101010 -> mem[5]=42, fill_valid at 6 cycles with fill_data=1, wb_count=1.
REQ-037 Same-address write-back: endereco=5, WB={1,1,4'd5,8'd99} -> fill_data=99.
REQ-038 Clean victim with WB_needed=1 (WB[12]=0) -> no write-back, fill after 3 cycles, wb_count unchanged.
REQ-039 Second miss_req during busy -> ignored; one fill pulse only; back-to-back miss accepted in first IDLE cycle.
REQ-040 Reset during WB_WAIT -> busy=0 immediately, no fill, mem[5] back to 5, wb_count=0.
